// File: rtl/example_fsm.sv
// Running-parity tracker: Y is high while an odd number of 1s has been sampled on X
// since the last synchronous reset.
//
//   state | meaning
//   ------+------------------------------------------
//   EVEN  | even count of 1s since reset, Y=0
//   ODD   | odd count of 1s since reset, Y=1
module example_fsm (
  input  logic clk,
  input  logic reset,
  input  logic X,
  output logic Y
);

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EVEN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EVEN:    if (X) state_nxt = ODD;
      ODD:     if (X) state_nxt = EVEN;
      default: state_nxt = EVEN;
    endcase
  end

  // Y comes straight off the state flop, so X never reaches it combinationally.
  assign Y = (state == ODD);

endmodule

// File: tb/tb_example_fsm.sv
// Self-checking bench for example_fsm: directed literal cases plus a random stream
// compared every cycle against a history-queue parity model.
module tb_example_fsm;

  logic clk;
  logic reset;
  logic X;
  logic Y;

  int checks   = 0;
  int failures = 0;

  example_fsm dut (
    .clk   (clk),
    .reset (reset),
    .X     (X),
    .Y     (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every X bit accepted since the last reset edge.
  bit hist[$];
  bit model_valid = 1'b0;

  function automatic bit hist_parity();
    bit p = 1'b0;
    foreach (hist[i]) p = p ^ hist[i];
    return p;
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      hist.delete();
      model_valid = 1'b1;
    end else if (model_valid) begin
      hist.push_back(X);
    end
  end

  // Mid-cycle compare against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (Y !== hist_parity()) begin
        failures++;
        $display("FAIL model_cmp t=%0t Y=%b expected=%b ones=%0d", $time, Y, hist_parity(),
                 hist.sum() with (int'(item)));
      end
    end
  end

  // Drive one edge worth of inputs; exp >= 0 pins Y to a literal just after the edge.
  task automatic step(input bit r, input bit x, input int exp, input string name);
    @(negedge clk);
    reset = r;
    X     = x;
    @(posedge clk);
    #1;
    if (exp >= 0) begin
      checks++;
      if (Y !== exp[0]) begin
        failures++;
        $display("FAIL %s Y=%b expected=%0d", name, Y, exp);
      end
    end
  endtask

  initial begin
    bit r;
    bit x;
    reset = 1'b1;
    X     = 1'b0;

    step(1, 0, 0, "reset_y0");
    step(0, 0, 0, "x0_after_reset");

    step(1, 1, 0, "reset_priority");
    step(0, 0, 0, "seq_0");
    step(0, 1, 1, "seq_1");
    step(0, 1, 0, "seq_2");
    step(0, 1, 1, "seq_3");
    step(0, 0, 1, "seq_4");

    step(1, 0, 0, "reset_before_ones");
    step(0, 1, 1, "ones_0");
    step(0, 1, 0, "ones_1");
    step(0, 1, 1, "ones_2");
    step(0, 1, 0, "ones_3");

    step(1, 0, 0, "reset_before_hold");
    step(0, 1, 1, "enter_odd");
    for (int i = 0; i < 5; i++) step(0, 0, 1, "hold_odd");

    step(1, 1, 0, "reset_in_odd");
    step(1, 1, 0, "reset_held");
    step(0, 1, 1, "after_reset_x1");

    for (int i = 0; i < 200; i++) begin
      r = ($urandom_range(0, 19) == 0);
      x = 1'($urandom_range(0, 1));
      step(r, x, r ? 0 : -1, "rand_reset");
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
